// File: rtl/fpa_result_reader.sv
// Drains NUM_WORDS results from the FP adder's result RAM (address 0 upward) onto a
// valid/ready stream, tagging each word with its IEEE-754 single-precision class.
module fpa_result_reader #(
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_oe,
    output logic              ram_rw,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned FLAG_W = 4;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic                oe_q, oe_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // {nan, inf, zero, denorm}; normal numbers classify as all-zero.
    function automatic logic [FLAG_W-1:0] class_flags(input logic [31:0] w);
        logic [7:0]  e;
        logic [22:0] m;
        e = w[30:23];
        m = w[22:0];
        return {(e == 8'hFF) && (m != 23'd0),
                (e == 8'hFF) && (m == 23'd0),
                (e == 8'h00) && (m == 23'd0),
                (e == 8'h00) && (m != 23'd0)};
    endfunction

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        oe_d    = 1'b0;
        data_d  = data_q;
        flags_d = flags_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    index_d = '0;
                    oe_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_FETCH: begin
                data_d  = ram_data;
                flags_d = class_flags(ram_data[31:0]);
                valid_d = 1'b1;
                last_d  = (index_q == LAST_IDX);
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                // Payload stays frozen until the consumer takes it.
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                        oe_d    = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            index_q <= '0;
            oe_q    <= 1'b0;
            data_q  <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            oe_q    <= oe_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ram_addr  = index_q;
    assign ram_oe    = oe_q;
    assign ram_rw    = 1'b0;
    assign out_data  = data_q;
    assign out_flags = flags_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fpa_result_reader.sv
// Bench for fpa_result_reader: directed scenarios plus randomized dumps checked against a
// queue-based scoreboard with arithmetic float classification.
module tb_fpa_result_reader;

    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  ram_addr;
    logic        ram_oe;
    logic        ram_rw;
    logic [31:0] ram_data;
    logic [31:0] out_data;
    logic [3:0]  out_flags;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] mem [N];
    logic [31:0] exp_q [$];
    logic [3:0]  obs_flags [N];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int accepts = 0;
    int start_cyc = 0;
    int first_valid_cyc = -1;

    fpa_result_reader #(.ADDR_W(2), .NUM_WORDS(N), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ram_addr(ram_addr), .ram_oe(ram_oe), .ram_rw(ram_rw), .ram_data(ram_data),
        .out_data(out_data), .out_flags(out_flags), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Poison value when not enabled so a capture without ram_oe is visible.
    assign ram_data = ram_oe ? mem[ram_addr] : 32'hDEAD_BEEF;

    function automatic logic [3:0] ref_flags(input logic [31:0] w);
        int unsigned e, m;
        e = (w / 32'h0080_0000) % 256;
        m = w % 32'h0080_0000;
        if (e == 255) return (m != 0) ? 4'b1000 : 4'b0100;
        if (e == 0)   return (m != 0) ? 4'b0001 : 4'b0010;
        return 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [31:0] w;
        if (out_valid && out_ready) begin
            chk("sb_word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("sb_data", out_data, w);
                chk("sb_flags", 32'(out_flags), 32'(ref_flags(w)));
                chk("sb_last", 32'(out_last), 32'(accepts == N - 1));
            end
            if (accepts < N) obs_flags[accepts] = out_flags;
            accepts++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        chk("ram_rw_low", 32'(ram_rw), 32'd0);
        chk("ram_addr_range", 32'(ram_addr <= 2'(N - 1)), 32'd1);
        chk("oe_not_with_valid", 32'(ram_oe & out_valid), 32'd0);
    endtask

    task automatic begin_dump();
        accepts = 0;
        done_cnt = 0;
        first_valid_cyc = -1;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
        chk("pre_start_idle", 32'(busy), 32'd0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        start_cyc = cyc;
        chk("launch_busy", 32'(busy), 32'd1);
        chk("launch_oe", 32'(ram_oe), 32'd1);
        chk("launch_addr", 32'(ram_addr), 32'd0);
    endtask

    task automatic run_until_done(input int budget, input bit rnd, input bit lat);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            n++;
        end
        out_ready = 1'b1;
        chk("done_seen", 32'(done_cnt), 32'd1);
        chk("busy_low_with_done", 32'(busy), 32'd0);
        chk("valid_low_with_done", 32'(out_valid), 32'd0);
        if (lat) begin
            chk("first_valid_latency", 32'(first_valid_cyc - start_cyc), 32'd1);
            chk("done_latency", 32'(done_cyc - start_cyc), 32'(2 * N + 1));
        end
        repeat (3) cycle();
        chk("done_single_pulse", 32'(done_cnt), 32'd1);
        chk("word_count", 32'(accepts), 32'(N));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("idle_after_dump", 32'(busy), 32'd0);
        chk("hold_last_data", out_data, mem[N - 1]);
        chk("hold_last_flags", 32'(out_flags), 32'(ref_flags(mem[N - 1])));
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_addr"}, 32'(ram_addr), 32'd0);
        chk({pfx, "_oe"}, 32'(ram_oe), 32'd0);
        chk({pfx, "_rw"}, 32'(ram_rw), 32'd0);
        chk({pfx, "_data"}, out_data, 32'd0);
        chk({pfx, "_flags"}, 32'(out_flags), 32'd0);
        chk({pfx, "_valid"}, 32'(out_valid), 32'd0);
        chk({pfx, "_last"}, 32'(out_last), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic load_basic();
        mem[0] = 32'h3F80_0000;
        mem[1] = 32'h4040_0000;
        mem[2] = 32'h4120_0000;
        mem[3] = 32'h3F60_0000;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        load_basic();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        cycle();

        // Basic dump, consumer always ready
        begin_dump();
        run_until_done(40, 1'b0, 1'b1);
        chk("normal_flags_w0", 32'(obs_flags[0]), 32'd0);

        // Stall on word 1 for five cycles
        begin_dump();
        n = 0;
        while (!(accepts == 1 && out_valid) && n < 20) begin cycle(); n++; end
        chk("stall_reached", 32'(accepts == 1 && out_valid), 32'd1);
        out_ready = 1'b0;
        repeat (5) begin
            cycle();
            chk("stall_data", out_data, 32'h4040_0000);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_oe", 32'(ram_oe), 32'd0);
            chk("stall_last", 32'(out_last), 32'd0);
        end
        out_ready = 1'b1;
        run_until_done(40, 1'b0, 1'b0);

        // Special-value classification
        mem[0] = 32'h7F80_0000;
        mem[1] = 32'h7FC0_0000;
        mem[2] = 32'h8000_0000;
        mem[3] = 32'h0000_0001;
        begin_dump();
        run_until_done(40, 1'b0, 1'b1);
        chk("flags_inf", 32'(obs_flags[0]), 32'h4);
        chk("flags_nan", 32'(obs_flags[1]), 32'h8);
        chk("flags_negzero", 32'(obs_flags[2]), 32'h2);
        chk("flags_denorm", 32'(obs_flags[3]), 32'h1);

        // Async reset while word 2 is presented
        load_basic();
        begin_dump();
        out_ready = 1'b0;
        n = 0;
        while (!(accepts == 2 && out_valid) && n < 20) begin
            out_ready = !(accepts == 2);
            cycle();
            n++;
        end
        chk("pre_reset_word2", out_data, 32'h4120_0000);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        cycle();
        cycle();
        chk("midreset_no_done", 32'(done_cnt), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
        begin_dump();
        run_until_done(40, 1'b0, 1'b1);

        // Start re-pulsed while busy is ignored
        begin_dump();
        n = 0;
        while (!(accepts == 1 && out_valid) && n < 20) begin cycle(); n++; end
        start = 1'b1;
        cycle();
        start = 1'b0;
        run_until_done(40, 1'b0, 1'b0);

        // Randomized contents and consumer back-pressure
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < N; i++) begin
                logic [31:0] w;
                w = $urandom;
                case ($urandom_range(0, 4))
                    0: w = w | 32'h7F80_0000;
                    1: w = w & 32'h807F_FFFF;
                    2: w = (w & 32'h8000_0000) | 32'h7F80_0000;
                    3: w = w & 32'h8000_0000;
                    default: ;
                endcase
                mem[i] = w;
            end
            begin_dump();
            run_until_done(300, 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
